// File: rtl/signal_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : signal_frame_ctrl
// Brief   : Frames a sample stream into WINDOW_LEN windows for a ZCR engine and
//           returns index-tagged results. SIGNAL_FRAME_TIMEOUT_EN adds a WAIT watchdog.
// Rev     : 1.0 - initial release
// ============================================================================
module signal_frame_ctrl #(
    parameter int WINDOW_LEN     = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  frame_count,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [15:0] src_data,
    input  logic        src_valid,
    output logic        src_rdy,
    output logic        eng_init,
    output logic [15:0] eng_data,
    output logic        eng_valid,
    input  logic        eng_rdy,
    input  logic [7:0]  eng_zcr,
    input  logic        eng_zcr_valid,
    output logic        eng_zcr_rdy,
    output logic [7:0]  res_data,
    output logic [7:0]  res_index,
    output logic        res_valid,
    input  logic        res_rdy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [9:0] c_LAST_SAMPLE = 10'(WINDOW_LEN - 1);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [7:0] r_count;
    logic [7:0] r_index;
    logic [7:0] r_res_data;
    logic [9:0] r_sample_cnt;

    logic w_accept;
    logic w_xfer;
    logic w_capture;
    logic w_advance;
    logic w_last_frame;
    logic w_timeout;

    assign w_last_frame = (r_index == (r_count - 8'd1));
    assign res_data     = r_res_data;
    assign res_index    = r_index;

`ifdef SIGNAL_FRAME_TIMEOUT_EN
    localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_err;

    // Counter restarts on every entry to WAIT; it only runs while no result is offered.
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_WAIT)) begin
            r_wd_cnt <= '0;
        end else if (!eng_zcr_valid) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !eng_zcr_valid && (r_wd_cnt == c_WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_index      <= '0;
            r_sample_cnt <= '0;
            r_res_data   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_count <= frame_count;
                r_index <= '0;
            end else if (w_advance) begin
                r_index <= r_index + 8'd1;
            end
            if (r_state == S_INIT) begin
                r_sample_cnt <= '0;
            end else if (w_xfer) begin
                r_sample_cnt <= r_sample_cnt + 10'd1;
            end
            if (w_capture) begin
                r_res_data <= eng_zcr;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        done        = 1'b0;
        eng_init    = 1'b0;
        src_rdy     = 1'b0;
        eng_valid   = 1'b0;
        eng_data    = '0;
        eng_zcr_rdy = 1'b0;
        res_valid   = 1'b0;
        w_accept    = 1'b0;
        w_xfer      = 1'b0;
        w_capture   = 1'b0;
        w_advance   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (frame_count == 8'd0) ? S_DONE : S_INIT;
                end
            end
            S_INIT: begin
                eng_init    = 1'b1;
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                // Zero-latency pass-through: the engine's ready directly back-pressures the source.
                eng_data  = src_data;
                eng_valid = src_valid;
                src_rdy   = eng_rdy;
                w_xfer    = src_valid && eng_rdy;
                if (w_xfer && (r_sample_cnt == c_LAST_SAMPLE)) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                eng_zcr_rdy = 1'b1;
                if (eng_zcr_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_OUT;
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_rdy) begin
                    w_advance   = !w_last_frame;
                    w_state_nxt = w_last_frame ? S_DONE : S_INIT;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
